axis_systolic_stream_ctrl: RTL
==============================

// Module: axis_systolic_stream_ctrl
// PURPOSE
//  AXI4-Stream front end for the systolic matrix core, with full backpressure on both sides.
//  Splits each slave beat into A/B operands and drives the core's compute port.
//  Buffers core results in an output FIFO and drains them on the master stream.
//  Credit logic guarantees that every result the core produces has a free FIFO slot.
//  Sits between the DMA stream fabric and the core; the core is instantiated one level up.
// PARAMETERS
//  A_W              32   width of operand A (upper field of s_axis_data)
//  B_W              32   width of operand B (lower field of s_axis_data)
//  OUT_W            128  result / m_axis_data width
//  BEATS_PER_RESULT 4    accepted input beats per core result (group size, >=1)
//  FIFO_DEPTH       8    output FIFO entries, power of 2, >=2
// PORTS
//  axi_clk        in   1          clock
//  axi_rst_n      in   1          reset, asynchronous, active-low
//  s_axis_valid   in   1          slave beat valid
//  s_axis_data    in   A_W+B_W    {A,B}
//  s_axis_last    in   1          marks the last beat of a group
//  s_axis_ready   out  1          slave ready
//  m_axis_valid   out  1          master beat valid
//  m_axis_data    out  OUT_W      result
//  m_axis_ready   in   1          master ready
//  core_reset     out  1          = ~axi_rst_n (combinational), active-high core reset
//  core_valid_in  out  1          operand strobe to core
//  core_a         out  A_W        operand A
//  core_b         out  B_W        operand B
//  core_result    in   OUT_W      core result
//  core_valid_out in   1          core result strobe (arbitrary latency, in group order)
//  err_last       out  1          sticky: s_axis_last misaligned with the group boundary
//  err_ovf        out  1          sticky: core result arrived while the FIFO was full
// BEHAVIOUR
//  Reset values: all outputs 0 except core_reset; FIFO empty; beat_cnt=0; reserved=0.
//  Handshake: acc = s_axis_valid & s_axis_ready.
//    s_axis_ready depends on registered state only, never on s_axis_valid.
//  Credit rule: credits = FIFO_DEPTH - fifo_count - reserved.
//    s_axis_ready = (beat_cnt!=0) | (credits>0).
//  Group start: acc with beat_cnt==0 -> reserved+1. core_valid_out -> reserved-1, saturating at 0.
//  Simultaneous +1 and -1 on reserved in the same cycle -> no net change.
//  beat_cnt: on acc, increments; wraps to 0 at BEATS_PER_RESULT-1.
//  Last-beat check (on acc):
//    s_axis_last=1 with beat_cnt!=BPR-1 -> err_last set; beat_cnt forced to 0.
//    s_axis_last=0 with beat_cnt==BPR-1 -> err_last set; beat_cnt still wraps to 0.
//  Core drive, registered, 1-cycle latency:
//    core_valid_in <= acc; core_a/core_b <= data fields on acc, otherwise held.
//  Result capture: core_valid_out with FIFO not full -> write core_result.
//    With FIFO full -> result dropped, err_ovf set.
//    Write and pop in the same cycle are legal: count unchanged, including when the FIFO is full.
//  Master side: m_axis_valid = ~empty; m_axis_data = FIFO head, both from registers.
//    Pop on m_axis_valid & m_axis_ready.
//    Empty FIFO, core_valid_out at cycle t -> m_axis_valid=1 at t+1.
//    m_axis_data is held stable while valid & ~ready.
//  A freed credit (pop) is visible on s_axis_ready the following cycle.
//  Reset mid-operation: FIFO, counters and flags cleared at once; partial group discarded.
//    core_reset flushes the core in the same cycles.
//  err_* clear only on reset.
// CONFIGURATION
//  AXIS_SYS_STATS_EN defined:
//    adds outputs stat_in_beats[31:0], stat_out_beats[31:0], stat_stall_cyc[31:0].
//    stat_in_beats counts accepted slave beats; stat_out_beats counts popped master beats.
//    stat_stall_cyc counts cycles with s_axis_valid & ~s_axis_ready.
//    All counters wrap at 2^32 and reset to 0.
//  AXIS_SYS_STATS_EN undefined: these ports and counters do not exist; all other
//    behaviour is identical.
// TESTING
//  Bench setup: BPR=4, FIFO_DEPTH=2; the core model returns sum(A*B) 3 cycles after the 4th beat.
//  T1 Single group: 4 beats {1,2},{3,4},{5,6},{7,8} with last on beat 4, m_axis_ready=1
//     -> one result = 100; err_* stay 0.
//  T2 Backpressure: 3 groups back-to-back, m_axis_ready=0
//     -> 2 results are held in the FIFO; s_axis_ready=0 on beat 1 of group 3; err_ovf=0.
//     Then ready=1 -> all 3 results are delivered in order.
//  T3 Stall hold: m_axis_ready toggles 1010...
//     -> m_axis_data does not change while valid & ~ready; no beat is lost or duplicated.
//  T4 Misaligned last: last on beat 2 -> err_last=1 and the next beat starts a new group.
//     A later correct group still yields the correct result.
//  T5 Forced overflow: the model emits an extra unsolicited result with the FIFO full
//     -> err_ovf=1 and FIFO contents unchanged.
//  T6 Mid-stream reset: axi_rst_n low for 1 cycle in the middle of group 2
//     -> m_axis_valid=0, s_axis_ready=1 afterwards, and the next full group computes correctly.

Source files
------------

// File: rtl/axis_systolic_stream_ctrl.sv
// -----------------------------------------------------------------------------
// axis_systolic_stream_ctrl
//
// Purpose:
//   AXI4-Stream front end for the systolic matrix core.
//   - Each accepted slave beat is split into operands A (upper field) and
//     B (lower field). They are presented to the core one cycle later with a
//     compute strobe.
//   - Core results are buffered in an output FIFO and drained on the master
//     stream. Both sides support full backpressure.
//   - Credit logic reserves a FIFO slot when a group starts. This ensures
//     that every result the core produces has somewhere to land.
//
// Ports:
//   axi_clk, axi_rst_n            clock; asynchronous active-low reset
//   s_axis_valid/data/last/ready  slave stream, data = {A, B}
//   m_axis_valid/data/ready       master stream carrying core results
//   core_reset                    active-high core reset (= ~axi_rst_n)
//   core_valid_in, core_a, core_b operand strobe and operands to the core
//   core_result, core_valid_out   result and result strobe from the core
//   err_last                      sticky: s_axis_last off the group boundary
//   err_ovf                       sticky: core result dropped, FIFO full
//
// Optional feature (compile-time macro AXIS_SYS_STATS_EN):
//   Adds the free-running 32-bit counters stat_in_beats, stat_out_beats and
//   stat_stall_cyc. When the macro is undefined, those ports do not exist.
// -----------------------------------------------------------------------------
module axis_systolic_stream_ctrl #(
  parameter int A_W              = 32,
  parameter int B_W              = 32,
  parameter int OUT_W            = 128,
  parameter int BEATS_PER_RESULT = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst_n,
  input  logic                 s_axis_valid,
  input  logic [A_W+B_W-1:0]   s_axis_data,
  input  logic                 s_axis_last,
  output logic                 s_axis_ready,
  output logic                 m_axis_valid,
  output logic [OUT_W-1:0]     m_axis_data,
  input  logic                 m_axis_ready,
  output logic                 core_reset,
  output logic                 core_valid_in,
  output logic [A_W-1:0]       core_a,
  output logic [B_W-1:0]       core_b,
  input  logic [OUT_W-1:0]     core_result,
  input  logic                 core_valid_out,
  output logic                 err_last,
  output logic                 err_ovf
`ifdef AXIS_SYS_STATS_EN
  ,
  output logic [31:0]          stat_in_beats,
  output logic [31:0]          stat_out_beats,
  output logic [31:0]          stat_stall_cyc
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = (BEATS_PER_RESULT > 1) ? $clog2(BEATS_PER_RESULT) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              run_reg;          // 0 in reset, 1 from first clock after
  logic [BC_W-1:0]   beat_cnt_reg,   beat_cnt_next;
  logic [CNT_W-1:0]  reserved_reg,   reserved_next;
  logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]  rd_ptr_reg,     rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg,     wr_ptr_next;
  logic [OUT_W-1:0]  head_reg,       head_next;
  logic              m_valid_reg,    m_valid_next;
  logic              err_last_reg,   err_last_next;
  logic              err_ovf_reg,    err_ovf_next;
  logic              core_valid_in_reg;
  logic [A_W-1:0]    core_a_reg;
  logic [B_W-1:0]    core_b_reg;

  // Result storage. It has no reset, and the head is read through head_reg.
  logic [OUT_W-1:0]  mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and credit decode
  // ---------------------------------------------------------------------------
  logic               acc;
  logic               group_start;
  logic               beat_last;
  logic               pop;
  logic               fifo_full;
  logic               wr_en;
  logic               ovf_hit;
  logic [CNT_W:0]     slots_used;
  logic [PTR_W-1:0]   rd_ptr_inc;

  // The slots used are the entries already in the FIFO plus the results still
  // owed by groups in flight. A new group may only start while this is below
  // the FIFO depth.
  assign slots_used   = {1'b0, fifo_count_reg} + {1'b0, reserved_reg};
  assign s_axis_ready = run_reg &
                        ((beat_cnt_reg != '0) || (slots_used < (CNT_W+1)'(FIFO_DEPTH)));

  assign acc         = s_axis_valid & s_axis_ready;
  assign group_start = acc & (beat_cnt_reg == '0);
  assign beat_last   = (beat_cnt_reg == BC_W'(BEATS_PER_RESULT - 1));

  assign pop         = m_valid_reg & m_axis_ready;
  assign fifo_full   = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en       = core_valid_out & (~fifo_full | pop);
  assign ovf_hit     = core_valid_out & fifo_full & ~pop;
  assign rd_ptr_inc  = rd_ptr_reg + PTR_W'(1);

  assign m_axis_valid  = m_valid_reg;
  assign m_axis_data   = head_reg;
  assign core_reset    = ~axi_rst_n;
  assign core_valid_in = core_valid_in_reg;
  assign core_a        = core_a_reg;
  assign core_b        = core_b_reg;
  assign err_last      = err_last_reg;
  assign err_ovf       = err_ovf_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_cnt_next   = beat_cnt_reg;
    reserved_next   = reserved_reg;
    fifo_count_next = fifo_count_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    head_next       = head_reg;
    err_last_next   = err_last_reg;
    err_ovf_next    = err_ovf_reg;

    // Group beat counter. An early last truncates the group, and a missing
    // last still wraps at the group size. Both cases are flagged.
    if (acc) begin
      if (s_axis_last || beat_last) begin
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + BC_W'(1);
      end
      if (s_axis_last != beat_last) begin
        err_last_next = 1'b1;
      end
    end

    // Reservations: +1 per group started, -1 per result returned (floor 0).
    case ({group_start, core_valid_out})
      2'b10:   reserved_next = reserved_reg + CNT_W'(1);
      2'b01:   reserved_next = (reserved_reg != '0) ? reserved_reg - CNT_W'(1) : '0;
      default: reserved_next = reserved_reg;
    endcase

    if (ovf_hit) begin
      err_ovf_next = 1'b1;
    end

    // FIFO pointers and occupancy.
    fifo_count_next = fifo_count_reg + CNT_W'(wr_en) - CNT_W'(pop);
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_inc;
    end

    // The head register always mirrors the oldest entry. After a pop, it takes
    // the next stored entry. If the pop leaves only the entry being written,
    // the head bypasses to the incoming result instead.
    if (pop) begin
      if (fifo_count_reg > CNT_W'(1)) begin
        head_next = mem[rd_ptr_inc];
      end else if (wr_en) begin
        head_next = core_result;
      end
    end else if (wr_en && (fifo_count_reg == '0)) begin
      head_next = core_result;
    end
  end

  assign m_valid_next = (fifo_count_next != '0);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      run_reg           <= 1'b0;
      beat_cnt_reg      <= '0;
      reserved_reg      <= '0;
      fifo_count_reg    <= '0;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      head_reg          <= '0;
      m_valid_reg       <= 1'b0;
      err_last_reg      <= 1'b0;
      err_ovf_reg       <= 1'b0;
      core_valid_in_reg <= 1'b0;
      core_a_reg        <= '0;
      core_b_reg        <= '0;
    end else begin
      run_reg           <= 1'b1;
      beat_cnt_reg      <= beat_cnt_next;
      reserved_reg      <= reserved_next;
      fifo_count_reg    <= fifo_count_next;
      rd_ptr_reg        <= rd_ptr_next;
      wr_ptr_reg        <= wr_ptr_next;
      head_reg          <= head_next;
      m_valid_reg       <= m_valid_next;
      err_last_reg      <= err_last_next;
      err_ovf_reg       <= err_ovf_next;
      core_valid_in_reg <= acc;
      if (acc) begin
        core_a_reg <= s_axis_data[A_W+B_W-1:B_W];
        core_b_reg <= s_axis_data[B_W-1:0];
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= core_result;
    end
  end

`ifdef AXIS_SYS_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: [0] accepted slave beats, [1] popped master beats,
  // [2] slave stall cycles. The counters wrap at 2^32.
  // ---------------------------------------------------------------------------
  logic [2:0] stat_inc;
  assign stat_inc = {s_axis_valid & ~s_axis_ready, pop, acc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign stat_in_beats  = g_stat[0].cnt_reg;
  assign stat_out_beats = g_stat[1].cnt_reg;
  assign stat_stall_cyc = g_stat[2].cnt_reg;
`endif

endmodule
